muldiv_seq: RTL and testbench
=============================

MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin an operation.
REQ-005 The block SHALL have port op, input, 2 bits: 00 MUL (low WIDTH bits of product), 01 DIVU, 10 REMU, 11 treated as MUL.
REQ-006 The block SHALL have ports operand1 and operand2, input, WIDTH bits each: the unsigned operands.
REQ-007 The block SHALL have port busy, output, 1 bit: high while an operation is iterating.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, WIDTH bits: result of the last completed operation.
REQ-010 The block SHALL have port div_by_zero, output, 1 bit: the last completed DIVU/REMU had operand2 == 0.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 The block SHALL accept start only in IDLE or DONE, capturing op, operand1 and operand2 into internal registers on that edge.
REQ-013 An accepted start SHALL move the FSM to RUN, load the iteration counter with WIDTH and set busy = 1.
REQ-014 In RUN, each cycle SHALL perform exactly one iteration and decrement the counter.
- MUL: shift-add, one multiplier bit per cycle.
- DIVU/REMU: restoring division, one quotient bit per cycle.
REQ-015 When the counter reaches 0, the FSM SHALL enter DONE with busy = 0, done = 1 for exactly one cycle, and result and div_by_zero updated.
REQ-016 Nominal latency SHALL be WIDTH+1 cycles: done is high in cycle WIDTH+1 counted from the accepting edge.
REQ-017 With no start in DONE, DONE SHALL go to IDLE; a start in DONE SHALL be accepted (back-to-back), going directly to RUN.
REQ-018 start asserted in RUN SHALL be ignored, with no effect on state or the operation in flight.
REQ-019 Changes on op or the operand inputs after the accepting edge SHALL NOT affect the operation in flight.
REQ-020 result and div_by_zero SHALL hold their values from DONE until the next operation completes.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH.
- MUL: returns product[WIDTH-1:0].
- DIVU/REMU: return quotient and remainder respectively.
REQ-022 Division by zero SHALL follow RISC-V semantics and set div_by_zero = 1.
- DIVU: returns all ones.
- REMU: returns operand1.
REQ-023 MUL SHALL always clear div_by_zero.

Reset
REQ-024 rst high SHALL immediately force state = IDLE, busy = 0, done = 0, result = 0, div_by_zero = 0 and counter = 0, including in the middle of RUN.
REQ-025 The first rising clk edge after rst deasserts SHALL be able to accept start.

Configuration
REQ-026 Macro MULDIV_EARLY_OUT_EN SHALL enable early completion.
- Defined: DIVU/REMU with operand2 == 0, and MUL with either operand == 0, SHALL skip RUN and enter DONE on the edge after acceptance (latency 1, busy never high), with results per REQ-021/REQ-022.
- Undefined: these cases SHALL take the full WIDTH+1 latency with identical results.

Structure
REQ-027 A shared package muldiv_pkg SHALL hold the op encoding constants, the FSM state type, and the default WIDTH constant.
REQ-028 The per-iteration combinational datapath SHALL be a sub-module muldiv_step, instantiated once; the counter and FSM SHALL stay in muldiv_seq.

Verification
REQ-029 The bench SHALL cover these directed scenarios (WIDTH = 32):
- MUL 7 x 6 -> result 42, busy high 32 cycles, done pulse in cycle 33, div_by_zero 0.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> result 0x00000001; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF, div_by_zero 1; REMU 5/0 -> 5, div_by_zero 1; done in cycle 1 with MULDIV_EARLY_OUT_EN, cycle 33 without.
- start re-asserted and operands changed to 0 during RUN of MUL 3 x 5 -> ignored, result 15, single done pulse.
- start in DONE cycle (DIVU 9/2 then REMU 9/2) -> no IDLE cycle between; results 4 then 1, two done pulses 33 cycles apart.
- rst asserted at cycle 10 of RUN -> busy, done, result and div_by_zero 0 immediately; next MUL 2 x 2 -> 4 with normal latency.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the sequential multiply/divide unit.
//   DEFAULT_WIDTH : default operand/result width
//   OP_*          : operation encoding on the op port (2'b11 behaves as MUL)
//   state_t       : FSM state type used by muldiv_seq
//   op_is_div     : true for DIVU/REMU encodings
package muldiv_pkg;

    localparam int unsigned DEFAULT_WIDTH = 32;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REMU = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic op_is_div(input logic [1:0] op_i);
        return (op_i == OP_DIVU) || (op_i == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the shared multiply/divide datapath.
//   is_div   : 1 = restoring-division step, 0 = shift-add multiply step
//   operand2 : multiplicand (MUL) or divisor (DIVU/REMU)
//   acc      : upper half of the product / partial remainder
//   mq       : multiplier bits / dividend bits being shifted into the quotient
//   acc_c    : next acc value
//   mq_c     : next mq value
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] operand2,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    output logic [WIDTH-1:0] acc_c,
    output logic [WIDTH-1:0] mq_c
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, operand2} : '0);
        shifted = {acc, mq[WIDTH-1]};
        // acc < divisor holds, so the top bit of diff is a clean borrow flag.
        // A zero divisor never borrows: quotient becomes all ones and the
        // remainder collects operand1, matching the RISC-V zero-divide results.
        diff    = shifted - {1'b0, operand2};
        if (is_div) begin
            if (!diff[WIDTH]) begin
                acc_c = diff[WIDTH-1:0];
                mq_c  = {mq[WIDTH-2:0], 1'b1};
            end else begin
                acc_c = shifted[WIDTH-1:0];
                mq_c  = {mq[WIDTH-2:0], 1'b0};
            end
        end else begin
            // {acc, mq} shifts right; the low product collects in mq.
            acc_c = sum[WIDTH:1];
            mq_c  = {sum[0], mq[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned MUL / DIVU / REMU, one bit per clock.
//   clk, rst            : clock, asynchronous active-high reset
//   start, op           : request and operation (00 MUL, 01 DIVU, 10 REMU, 11 MUL)
//   operand1, operand2  : unsigned operands, captured on the accepting edge
//   busy                : high while iterating
//   done                : one-cycle pulse when result is valid
//   result              : result of the last completed operation
//   div_by_zero         : last completed DIVU/REMU had operand2 == 0
// Build option: define MULDIV_EARLY_OUT_EN to complete divide-by-zero and
// multiply-by-zero directly on the accepting edge.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   mq_q, mq_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               dbz_q, dbz_d;

    logic [WIDTH-1:0]   acc_c;
    logic [WIDTH-1:0]   mq_c;

`ifdef MULDIV_EARLY_OUT_EN
    logic               early_c;
    logic [WIDTH-1:0]   early_result_c;

    // Zero-operand cases whose result is known without iterating.
    always_comb begin
        early_c        = op_is_div(op) ? (operand2 == '0)
                                       : ((operand1 == '0) || (operand2 == '0));
        early_result_c = (op == OP_DIVU) ? '1 :
                         (op == OP_REMU) ? operand1 : '0;
    end
`endif

    muldiv_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .is_div   (op_is_div(op_q)),
        .operand2 (opb_q),
        .acc      (acc_q),
        .mq       (mq_q),
        .acc_c    (acc_c),
        .mq_c     (mq_c)
    );

    // Next-state, datapath and output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        mq_d     = mq_q;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        result_d = result_q;
        dbz_d    = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    op_d    = op;
                    opb_d   = operand2;
                    acc_d   = '0;
                    mq_d    = operand1;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = RUN;
                    busy_d  = 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
                    if (early_c) begin
                        cnt_d    = '0;
                        state_d  = DONE;
                        busy_d   = 1'b0;
                        done_d   = 1'b1;
                        result_d = early_result_c;
                        dbz_d    = op_is_div(op);
                    end
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_c;
                mq_d  = mq_c;
                cnt_d = cnt_q - CNT_W'(1);
                // Last iteration: publish the stepped values directly.
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    result_d = (op_q == OP_REMU) ? acc_c : mq_c;
                    dbz_d    = op_is_div(op_q) && (opb_q == '0);
                end else begin
                    busy_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= OP_MUL;
            opb_q    <= '0;
            acc_q    <= '0;
            mq_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            mq_q     <= mq_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq (WIDTH = 32).
// Cycle 1 is the clock period beginning at the edge that accepts start.
module tb_muldiv_seq;

    localparam int LAT = 33;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int ZLAT  = 1;
    localparam int ZBUSY = 0;
`else
    localparam int ZLAT  = 33;
    localparam int ZBUSY = 32;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    muldiv_seq #(
        .WIDTH       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .operand1    (operand1),
        .operand2    (operand2),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation and watch a fixed 45-cycle window after acceptance.
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb,
                         output int first_done, output int n_done, output int n_busy,
                         output logic [31:0] res, output logic dz);
        start    = 1'b1;
        op       = o;
        operand1 = a;
        operand2 = b;
        tick();
        start      = 1'b0;
        first_done = 0;
        n_done     = 0;
        n_busy     = 0;
        res        = '0;
        dz         = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (disturb && c == 5) begin
                start    = 1'b1;
                op       = 2'b01;
                operand1 = '0;
                operand2 = '0;
            end
            if (disturb && c == 20) start = 1'b0;
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (first_done == 0) begin
                    first_done = c;
                    res        = result;
                    dz         = div_by_zero;
                end
            end
            tick();
        end
    endtask

    int          fd, nd, nb, d1, d2;
    logic [31:0] r;
    logic        z;

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        operand1 = '0;
        operand2 = '0;

        #3;
        check("reset_busy",   32'(busy),        32'd0);
        check("reset_done",   32'(done),        32'd0);
        check("reset_result", result,           32'd0);
        check("reset_dbz",    32'(div_by_zero), 32'd0);
        tick();
        rst = 1'b0;

        // MUL 7 x 6, issued on the first edge after reset release
        do_op(2'b00, 32'd7, 32'd6, 1'b0, fd, nd, nb, r, z);
        check("mul7x6_result", r,         32'd42);
        check("mul7x6_lat",    32'(fd),   32'(LAT));
        check("mul7x6_busy",   32'(nb),   32'd32);
        check("mul7x6_pulses", 32'(nd),   32'd1);
        check("mul7x6_dbz",    32'(z),    32'd0);
        check("mul7x6_hold",   result,    32'd42);
        check("mul7x6_idle",   32'(done), 32'd0);

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, fd, nd, nb, r, z);
        check("mulmax_result", r,       32'h0000_0001);
        check("mulmax_lat",    32'(fd), 32'(LAT));

        do_op(2'b01, 32'd100, 32'd7, 1'b0, fd, nd, nb, r, z);
        check("divu100_7_result", r,       32'd14);
        check("divu100_7_dbz",    32'(z),  32'd0);
        check("divu100_7_lat",    32'(fd), 32'(LAT));

        do_op(2'b10, 32'd100, 32'd7, 1'b0, fd, nd, nb, r, z);
        check("remu100_7_result", r,       32'd2);
        check("remu100_7_lat",    32'(fd), 32'(LAT));

        // op 11 behaves as MUL
        do_op(2'b11, 32'd9, 32'd11, 1'b0, fd, nd, nb, r, z);
        check("op3_result", r, 32'd99);

        // start and operands disturbed while running MUL 3 x 5
        do_op(2'b00, 32'd3, 32'd5, 1'b1, fd, nd, nb, r, z);
        check("ignore_result", r,        32'd15);
        check("ignore_pulses", 32'(nd),  32'd1);
        check("ignore_lat",    32'(fd),  32'(LAT));
        check("ignore_busy",   32'(nb),  32'd32);
        check("ignore_hold",   result,   32'd15);

        // back-to-back: DIVU 9/2 then REMU 9/2 accepted in the DONE cycle
        start    = 1'b1;
        op       = 2'b01;
        operand1 = 32'd9;
        operand2 = 32'd2;
        tick();
        start = 1'b0;
        d1 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                d1 = c;
                break;
            end
            tick();
        end
        check("b2b_first_lat",    32'(d1), 32'(LAT));
        check("b2b_first_result", result,  32'd4);
        start    = 1'b1;
        op       = 2'b10;
        operand1 = 32'd9;
        operand2 = 32'd2;
        tick();
        start = 1'b0;
        check("b2b_no_idle_busy", 32'(busy), 32'd1);
        check("b2b_single_pulse", 32'(done), 32'd0);
        d2 = 0;
        for (int c = 1; c <= 40; c++) begin
            if (done) begin
                d2 = c;
                break;
            end
            tick();
        end
        check("b2b_pulse_spacing", 32'(d2),          32'd33);
        check("b2b_second_result", result,           32'd1);
        check("b2b_second_dbz",    32'(div_by_zero), 32'd0);
        repeat (3) tick();

        do_op(2'b01, 32'd5, 32'd0, 1'b0, fd, nd, nb, r, z);
        check("divu_by0_result", r,       32'hFFFF_FFFF);
        check("divu_by0_dbz",    32'(z),  32'd1);
        check("divu_by0_lat",    32'(fd), 32'(ZLAT));
        check("divu_by0_busy",   32'(nb), 32'(ZBUSY));

        do_op(2'b10, 32'd5, 32'd0, 1'b0, fd, nd, nb, r, z);
        check("remu_by0_result", r,                32'd5);
        check("remu_by0_dbz",    32'(z),           32'd1);
        check("remu_by0_lat",    32'(fd),          32'(ZLAT));
        check("remu_by0_hold",   32'(div_by_zero), 32'd1);

        // MUL clears div_by_zero; zero operand exercises the early-out path
        do_op(2'b00, 32'd0, 32'd9, 1'b0, fd, nd, nb, r, z);
        check("mul_zero_result", r,       32'd0);
        check("mul_zero_dbz",    32'(z),  32'd0);
        check("mul_zero_lat",    32'(fd), 32'(ZLAT));
        check("mul_zero_busy",   32'(nb), 32'(ZBUSY));

        do_op(2'b01, 32'd5, 32'd0, 1'b0, fd, nd, nb, r, z);
        check("pre_rst_dbz", 32'(div_by_zero), 32'd1);

        // reset in cycle 10 of a MUL
        start    = 1'b1;
        op       = 2'b00;
        operand1 = 32'hAB;
        operand2 = 32'hCD;
        tick();
        start = 1'b0;
        repeat (9) tick();
        check("midrun_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_busy",   32'(busy),        32'd0);
        check("rst_done",   32'(done),        32'd0);
        check("rst_result", result,           32'd0);
        check("rst_dbz",    32'(div_by_zero), 32'd0);
        tick();
        rst = 1'b0;

        do_op(2'b00, 32'd2, 32'd2, 1'b0, fd, nd, nb, r, z);
        check("post_rst_result", r,       32'd4);
        check("post_rst_lat",    32'(fd), 32'(LAT));
        check("post_rst_pulses", 32'(nd), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
